// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer.
//   seq_state_t   : phases of the operand-entry walk
//   OP_ADD/OP_SUB : the only opcodes whose carry/overflow/sign flags are meaningful
//   FLAG_W        : width of the {Cf,Of,Zf,Sf} flag bundle
//   qualify_flags : masks the flags the ALU does not drive for a given opcode
package alu_seq_pkg;

  localparam int FLAG_W = 4;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_OP,
    EXEC,
    SHOW
  } seq_state_t;

  // The ALU leaves Cf/Of/Sf floating on opcodes that do not produce them,
  // so they are forced to 0 here. Zf is valid for every opcode.
  function automatic logic [FLAG_W-1:0] qualify_flags(
    input logic [3:0] op,
    input logic       cf,
    input logic       of,
    input logic       zf,
    input logic       sf
  );
    logic arith;
    arith = (op == OP_ADD) || (op == OP_SUB);
    return {(op == OP_ADD) & cf, arith & of, zf, arith & sf};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-high counter and
// rising-edge detector. Produces one single-cycle pulse per accepted press.
//   clk, rst : system clock, synchronous active-high reset
//   btn      : raw asynchronous button level
//   press    : one-cycle pulse when the debounced level rises
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync_q1;
  logic        sync_q2;
  logic [15:0] stable_cnt;
  logic        level;
  logic        level_q;

  // The counter saturates at DEBOUNCE_CYCLES, so the level stays high for as
  // long as the button is held and no repeat press is generated.
  assign level = (stable_cnt == DEBOUNCE_CYCLES);
  assign press = level & ~level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable_cnt <= '0;
      level_q    <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      if (!sync_q2) begin
        stable_cnt <= '0;
      end else if (!level) begin
        stable_cnt <= stable_cnt + 16'd1;
      end
      level_q <= level;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Front-end controller for the 6-bit combinational ALU. Walks the user through
// entering operand A, operand B and the opcode with ENTER, holds them on the
// ALU inputs, captures result and qualified flags after they settle and shows
// them on the LEDs. CLEAR aborts back to operand A entry with everything zeroed.
//   clk, rst                 : system clock, synchronous active-high reset
//   sw[5:0]                  : operand data; sw[3:0] is the opcode
//   btn_enter, btn_clear     : raw buttons
//   alu_a, alu_b, alu_op     : ALU operand/opcode drive
//   alu_out, alu_cf/of/zf/sf : ALU result and flags
//   led, flag_led            : display value and latched {Cf,Of,Zf,Sf}
//   state_led                : one-hot {OP,B,A} entry phase
//   result_valid             : high while the result is shown
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  SETTLE_CYCLES   = 4'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [5:0]        alu_a,
  output logic [5:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [5:0]        alu_out,
  input  logic              alu_cf,
  input  logic              alu_of,
  input  logic              alu_zf,
  input  logic              alu_sf,
  output logic [5:0]        led,
  output logic [FLAG_W-1:0] flag_led,
  output logic [2:0]        state_led,
  output logic              result_valid
);

  logic enter_p;
  logic clear_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .press (enter_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clear),
    .press (clear_p)
  );

  seq_state_t        state_q, state_d;
  logic [5:0]        a_d, b_d;
  logic [3:0]        op_d;
  logic [5:0]        led_q, led_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic              valid_d;
  logic [3:0]        settle_q, settle_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = alu_a;
    b_d      = alu_b;
    op_d     = alu_op;
    led_d    = led_q;
    flag_d   = flag_q;
    valid_d  = result_valid;
    settle_d = settle_q;

    if (clear_p) begin
      // Clear outranks a simultaneous enter.
      state_d  = LOAD_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      led_d    = '0;
      flag_d   = '0;
      valid_d  = 1'b0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (enter_p) begin
            a_d     = sw;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_p) begin
            b_d     = sw;
            state_d = LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (enter_p) begin
            op_d     = sw[3:0];
            settle_d = '0;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          // alu_op is already the registered opcode the ALU is computing on.
          if (settle_q == SETTLE_CYCLES - 4'd1) begin
            led_d   = alu_out;
            flag_d  = qualify_flags(alu_op, alu_cf, alu_of, alu_zf, alu_sf);
            valid_d = 1'b1;
            state_d = SHOW;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        SHOW: begin
          if (enter_p) begin
            valid_d = 1'b0;
            state_d = LOAD_A;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      led_q        <= '0;
      flag_q       <= '0;
      result_valid <= 1'b0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      alu_a        <= a_d;
      alu_b        <= b_d;
      alu_op       <= op_d;
      led_q        <= led_d;
      flag_q       <= flag_d;
      result_valid <= valid_d;
      settle_q     <= settle_d;
    end
  end

  // During entry the LEDs follow the switches live; once the result is
  // captured they show the latched value.
  always_comb begin
    led       = led_q;
    state_led = 3'b000;
    unique case (state_q)
      LOAD_A:  begin led = sw;                 state_led = 3'b001; end
      LOAD_B:  begin led = sw;                 state_led = 3'b010; end
      LOAD_OP: begin led = {2'b00, sw[3:0]};   state_led = 3'b100; end
      default: begin led = led_q;              state_led = 3'b000; end
    endcase
  end

  assign flag_led = flag_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a small behavioural 6-bit ALU attached.
// Expected display values are pushed to a queue when an operation is keyed in
// and popped by a monitor when result_valid rises.
module tb_alu_operand_sequencer;

  localparam logic [15:0] DB     = 16'd4;
  localparam logic [3:0]  SETTLE = 4'd2;
  // btn edge -> 2 sync flops -> DB counts -> FSM edge -> SETTLE cycles
  localparam int LATENCY = 2 + 4 + 1 + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [5:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic [5:0] alu_out;
  logic       alu_cf, alu_of, alu_zf, alu_sf;
  logic [5:0] led;
  logic [3:0] flag_led;
  logic [2:0] state_led;
  logic       result_valid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0] led;
    logic [3:0] flags;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_cf       (alu_cf),
    .alu_of       (alu_of),
    .alu_zf       (alu_zf),
    .alu_sf       (alu_sf),
    .led          (led),
    .flag_led     (flag_led),
    .state_led    (state_led),
    .result_valid (result_valid)
  );

  // Stand-in ALU. Flags it does not produce for an opcode are driven high so
  // that missing masking in the sequencer shows up.
  always_comb begin
    logic [6:0] wide;
    wide    = '0;
    alu_out = '0;
    alu_cf  = 1'b1;
    alu_of  = 1'b1;
    alu_sf  = 1'b1;
    case (alu_op)
      4'b0000: begin
        wide    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = wide[5:0];
        alu_cf  = wide[6];
        alu_of  = (alu_a[5] == alu_b[5]) && (alu_out[5] != alu_a[5]);
        alu_sf  = alu_out[5];
      end
      4'b0001: begin
        wide    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = wide[5:0];
        alu_cf  = wide[6];
        alu_of  = (alu_a[5] != alu_b[5]) && (alu_out[5] != alu_a[5]);
        alu_sf  = alu_out[5];
      end
      4'b0111: alu_out = alu_a & alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
    alu_zf = (alu_out == 6'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every rising edge of result_valid must match the
  // oldest queued expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", {31'd0, result_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_led", {26'd0, led}, {26'd0, e.led});
        check("result_flags", {28'd0, flag_led}, {28'd0, e.flags});
      end
    end
    prev_valid <= result_valid;
  end

  task automatic press_enter(input int hold);
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_op(input logic [5:0] a, input logic [5:0] b, input logic [3:0] op,
                       input logic [5:0] exp_led, input logic [3:0] exp_flags,
                       input int hold_a);
    int cycles;
    sw = a;
    press_enter(hold_a);
    check("after_a_state", {29'd0, state_led}, 32'b010);
    sw = b;
    press_enter(10);
    check("after_b_state", {29'd0, state_led}, 32'b100);
    sw = {2'b11, op};
    #1;
    check("op_led_mask", {26'd0, led}, {28'd0, op});
    sb_q.push_back('{led: exp_led, flags: exp_flags});
    @(negedge clk);
    btn_enter = 1'b1;
    cycles = 0;
    while (!result_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("valid_latency", cycles, LATENCY);
    btn_enter = 1'b0;
    check("show_state", {29'd0, state_led}, 32'd0);
    check("show_a", {26'd0, alu_a}, {26'd0, a});
    check("show_b", {26'd0, alu_b}, {26'd0, b});
    repeat (8) @(negedge clk);
    check("show_hold_led", {26'd0, led}, {26'd0, exp_led});
    check("show_hold_valid", {31'd0, result_valid}, 32'd1);
    press_enter(10);
    check("back_valid", {31'd0, result_valid}, 32'd0);
    check("back_state", {29'd0, state_led}, 32'b001);
    check("keep_a", {26'd0, alu_a}, {26'd0, a});
    check("keep_op", {28'd0, alu_op}, {28'd0, op});
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    sw        = 6'd0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and live switch mirroring.
    check("rst_state", {29'd0, state_led}, 32'b001);
    check("rst_led", {26'd0, led}, 32'd0);
    sw = 6'b101010;
    #1;
    check("idle_led", {26'd0, led}, 32'b101010);
    check("rst_a", {26'd0, alu_a}, 32'd0);
    check("rst_b", {26'd0, alu_b}, 32'd0);
    check("rst_op", {28'd0, alu_op}, 32'd0);
    check("rst_flags", {28'd0, flag_led}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);

    // 5 + 3 = 8, no flags.
    do_op(6'b000101, 6'b000011, 4'b0000, 6'b001000, 4'b0000, 10);
    // -32 + -32 wraps to 0: carry, overflow, zero.
    do_op(6'b100000, 6'b100000, 4'b0000, 6'b000000, 4'b1110, 10);
    // 1 - 2 = -1: sign only, carry masked for SUB.
    do_op(6'b000001, 6'b000010, 4'b0001, 6'b111111, 4'b0001, 10);
    // AND with the first enter held 100 cycles: single press, flags masked.
    do_op(6'b101010, 6'b101010, 4'b0111, 6'b101010, 4'b0000, 100);

    // Clear while in LOAD_OP.
    sw = 6'd7;
    press_enter(10);
    sw = 6'd9;
    press_enter(10);
    check("clr_pre_state", {29'd0, state_led}, 32'b100);
    @(negedge clk);
    btn_clear = 1'b1;
    repeat (10) @(negedge clk);
    btn_clear = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_state", {29'd0, state_led}, 32'b001);
    check("clr_a", {26'd0, alu_a}, 32'd0);
    check("clr_b", {26'd0, alu_b}, 32'd0);
    check("clr_op", {28'd0, alu_op}, 32'd0);
    check("clr_flags", {28'd0, flag_led}, 32'd0);
    check("clr_valid", {31'd0, result_valid}, 32'd0);

    // Reset during EXEC.
    sw = 6'd3;
    press_enter(10);
    sw = 6'd4;
    press_enter(10);
    sw = 6'd0;
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (LATENCY - 2) @(negedge clk);
    check("exec_state", {29'd0, state_led}, 32'd0);
    rst       = 1'b1;
    btn_enter = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_exec_state", {29'd0, state_led}, 32'b001);
    check("rst_exec_a", {26'd0, alu_a}, 32'd0);
    check("rst_exec_b", {26'd0, alu_b}, 32'd0);
    check("rst_exec_valid", {31'd0, result_valid}, 32'd0);
    repeat (10) @(negedge clk);
    check("rst_exec_valid_later", {31'd0, result_valid}, 32'd0);

    // Three-cycle glitch is not a press.
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_state", {29'd0, state_led}, 32'b001);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end controller that drives the 6-bit combinational ALU from board switches and a single ENTER button.
- Walks the user through loading operand A, then operand B, then the opcode; holds the values on the ALU inputs; captures result and flags once they have settled; shows them on LEDs.
- Sits between the board I/O and the ALU instance: it is the ALU's operand source and its result consumer.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable-high clk cycles before a button press is accepted.
- SETTLE_CYCLES, 4'd2, clk cycles the ALU inputs are held before result and flags are captured (minimum 1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sw  input  6  switch value; operand data, with sw[3:0] used as opcode
- btn_enter  input  1  raw, asynchronous ENTER button
- btn_clear  input  1  raw CLEAR button, debounced the same way as ENTER
- alu_a  output  6  operand A to ALU
- alu_b  output  6  operand B to ALU
- alu_op  output  4  opcode to ALU
- alu_out  input  6  ALU result
- alu_cf, alu_of, alu_zf, alu_sf  input  1 each  ALU flags
- led  output  6  display value
- flag_led  output  4  {Cf,Of,Zf,Sf} as latched
- state_led  output  3  one-hot current phase {OP,B,A}; all zero in EXEC/SHOW
- result_valid  output  1  high while in SHOW

Behaviour:
- Reset value of every output: alu_a=0, alu_b=0, alu_op=0, led=0, flag_led=0, state_led=3'b001, result_valid=0. State after reset is LOAD_A.
- Buttons:
  - 2-flop synchroniser, then a debounce counter, then a rising-edge detector.
  - The counter resets to 0 whenever the synchronised level is low.
  - Debounced level goes high when the counter reaches DEBOUNCE_CYCLES.
  - One single-cycle press pulse per debounced rising edge. Holding the button gives no repeat.
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW.
- LOAD_A: led mirrors sw live. On an enter pulse, alu_a <= sw and the FSM moves to LOAD_B.
- LOAD_B: led mirrors sw. On enter, alu_b <= sw and the FSM moves to LOAD_OP.
- LOAD_OP: led = {2'b00, sw[3:0]}. On enter, alu_op <= sw[3:0], the settle counter clears, and the FSM moves to EXEC.
- EXEC: counts SETTLE_CYCLES cycles. On the last cycle it latches led <= alu_out and the flags, sets result_valid, and moves to SHOW. Enter pulses during EXEC are ignored.
- Flag qualification (the ALU drives undriven values on unsupported flags, so they must be masked):
  - Zf latched for every opcode.
  - Sf and Of latched only when alu_op is 0000 or 0001; otherwise 0.
  - Cf latched only when alu_op is 0000; otherwise 0.
- SHOW: led and flag_led hold. On enter, result_valid <= 0 and the FSM returns to LOAD_A. alu_a, alu_b and alu_op keep their values until overwritten.
- Clear pulse in any state: the FSM returns to LOAD_A, and alu_a/alu_b/alu_op/led/flag_led/result_valid are zeroed.
- Clear and enter pulses in the same cycle: clear wins.
- rst asserted mid-operation, including during EXEC: full reset on that clock edge. The debounce counters and synchronisers are also cleared.
- Opcodes 1100–1111 are accepted unchanged. The captured alu_out is whatever the ALU presents; only the flag masking above applies.
- Latency from the last enter pulse to result_valid = 1 + SETTLE_CYCLES clk cycles.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum seq_state_t (LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW);
  - opcode constants OP_ADD=4'b0000 and OP_SUB=4'b0001;
  - localparam FLAG_W=4.
- One sub-module, button_debounce (synchroniser + counter + edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan (all with DEBOUNCE_CYCLES=4, SETTLE_CYCLES=2, real ALU instance):
- Reset then idle → state_led=001; led follows sw=6'b101010; all other outputs 0.
- sw=000101 enter, sw=000011 enter, sw=0000 enter → led=001000, flag_led=0000, result_valid high exactly 3 cycles after the third pulse.
- a=100000, b=100000, op=0000 → led=000000, Zf=1, Of=1, Sf=0.
- a=000001, b=000010, op=0001 → led=111111, Sf=1, Of=0, Zf=0.
- op=0111 (AND) with a=b=101010 → led=101010, flag_led=0000 (Cf/Of/Sf masked). Button held high for 100 cycles produces one press only.
- Clear pulse while in LOAD_OP, and separately rst during EXEC → back in LOAD_A with operands zero and result_valid never asserted. A 3-cycle glitch on btn_enter produces no press.
